color_peak_tracker: RTL and testbench
=====================================

// Module: color_peak_tracker
// PURPOSE
//  Downstream of the per-pixel colour cost stage. Consumes the raster stream of
//  red/green/blue costs plus pixel coordinates and tracks, per colour, the
//  highest-cost pixel of each frame. At frame end it reports one (x,y) target
//  per colour with a found flag, for the laser projector's aiming logic.
// PARAMETERS
//  XW        10  pixel x coordinate width
//  YW        10  pixel y coordinate width
//  CW        9   cost width (matches cost stage outputs)
//  MIN_COST  4   cost >= MIN_COST counts as a hit for that colour
//  MIN_HITS  3   hits per frame required for found=1
//  HW        8   hit counter width (saturating)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  frame_start    in   1   pulse: a new frame begins (before its first pixel)
//  frame_end      in   1   pulse: frame complete (may coincide with last pixel)
//  pixel_valid    in   1   cost/coord inputs valid this cycle
//  pixel_x        in   XW  column of current pixel
//  pixel_y        in   YW  row of current pixel
//  red_cost       in   CW  red cost of current pixel
//  green_cost     in   CW  green cost of current pixel
//  blue_cost      in   CW  blue cost of current pixel
//  red_x/red_y    out  XW/YW  red target coordinate
//  green_x/green_y out XW/YW  green target coordinate
//  blue_x/blue_y  out  XW/YW  blue target coordinate
//  red_found, green_found, blue_found  out 1  colour target valid this report
//  result_valid   out  1   one-cycle pulse: all target outputs updated
//  busy           out  1   high while in ACCUM or REPORT
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; per-colour best cost/coord/hits cleared.
//  - Input stage: pixel_valid, coords, costs, frame_end registered once (S1);
//    all compares operate on S1. frame_start acts directly (not registered).
//  - States: IDLE -frame_start-> ACCUM -S1 frame_end-> REPORT -1 cycle-> IDLE.
//  - ACCUM, per colour c, when S1 pixel_valid and cost_c >= MIN_COST:
//    hits_c <= sat(hits_c+1) (holds at 2^HW-1); if cost_c > best_c
//    (strict) then best_c <= cost_c, coord_c <= S1 (x,y). Ties: first pixel
//    in raster order wins. Colours update independently in the same cycle.
//  - REPORT: found_c = (hits_c >= MIN_HITS); coord outputs loaded; result_valid
//    high for exactly this cycle; then best/hits cleared, state IDLE.
//  - Latency: frame_end at cycle N -> result_valid at cycle N+2.
//  - Outputs hold between reports; only REPORT changes them.
//  - Pixel valid in same cycle as frame_end: included in that frame.
//  - frame_start during ACCUM: discard accumulation, clear best/hits, stay
//    ACCUM (restart). frame_start during REPORT: report completes, state goes
//    to ACCUM with cleared accumulators (no frame lost).
//  - frame_end or pixel_valid in IDLE: ignored, no report.
//  - Cost 0 never a hit provided MIN_COST >= 1; MIN_COST=0 is illegal.
//  - reset asserted mid-frame: immediate return to IDLE, no result_valid.
// CONFIGURATION
//  TRACK_HOLD_EN defined: colour with found=0 keeps its previous x/y outputs
//   (last good target retained; only found flag drops).
//  TRACK_HOLD_EN undefined: colour with found=0 drives x/y = 0 at REPORT.
// TESTING
//  1 reset, then frame_start, 5 pixels red_cost=6 at (10,2)..(14,2), frame_end
//    -> result_valid 2 cycles after frame_end, red_found=1, red=(10,2), others 0.
//  2 red costs 5,9,9,7 at x=1..4,y=0 -> red=(2,0) (strict > tie rule).
//  3 only 2 green hits cost 8 at (3,3) -> green_found=0; green x/y=0 without
//    TRACK_HOLD_EN, previous frame's coords with TRACK_HOLD_EN.
//  4 frame_start mid-frame after red peak 12 at (50,40); new frame peak 7 at
//    (5,5) x3 -> red=(5,5); old peak discarded.
//  5 last pixel blue=15 at (639,479) coincident with frame_end -> blue=(639,479).
//  6 reset pulse mid-ACCUM then frame_end -> no result_valid, outputs stay 0.

Source files
------------

// File: rtl/color_peak_tracker.sv
// ---------------------------------------------------------------------------
// color_peak_tracker
//
// Purpose:
//   Sits downstream of the per-pixel colour cost stage. For each frame it
//   tracks, independently for red, green and blue, the highest-cost pixel
//   and how many pixels reached the hit threshold. At frame end it reports
//   one (x,y) target per colour plus a found flag for the projector aiming
//   logic.
//
// Configuration macro:
//   TRACK_HOLD_EN - when defined, a colour whose found flag is 0 at a
//                   report keeps its previous x/y outputs. When undefined,
//                   such a colour drives x/y = 0.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   frame_start         pulse, new frame begins (acts without input staging)
//   frame_end           pulse, frame complete (may coincide with last pixel)
//   pixel_valid         pixel_x/pixel_y/costs valid this cycle
//   pixel_x, pixel_y    current pixel coordinate
//   red/green/blue_cost current pixel costs
//   <c>_x, <c>_y        per-colour target coordinate
//   <c>_found           per-colour target valid in the latest report
//   result_valid        one-cycle pulse, all target outputs just updated
//   busy                high while accumulating or reporting
// ---------------------------------------------------------------------------
module color_peak_tracker #(
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int CW       = 9,
  parameter int MIN_COST = 4,
  parameter int MIN_HITS = 3,
  parameter int HW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          pixel_valid,
  input  logic [XW-1:0] pixel_x,
  input  logic [YW-1:0] pixel_y,
  input  logic [CW-1:0] red_cost,
  input  logic [CW-1:0] green_cost,
  input  logic [CW-1:0] blue_cost,
  output logic [XW-1:0] red_x,
  output logic [YW-1:0] red_y,
  output logic [XW-1:0] green_x,
  output logic [YW-1:0] green_y,
  output logic [XW-1:0] blue_x,
  output logic [YW-1:0] blue_y,
  output logic          red_found,
  output logic          green_found,
  output logic          blue_found,
  output logic          result_valid,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] MIN_COST_C = CW'(MIN_COST);
  localparam logic [HW-1:0] MIN_HITS_C = HW'(MIN_HITS);
  localparam logic [HW-1:0] HITS_MAX_C = {HW{1'b1}};
  localparam logic [HW-1:0] HITS_ONE_C = {{(HW-1){1'b0}}, 1'b1};

  // Saturating hit counter increment: holds at all-ones.
  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] h);
    logic [HW-1:0] r;
    if (h == HITS_MAX_C) begin
      r = h;
    end else begin
      r = h + HITS_ONE_C;
    end
    return r;
  endfunction

  // Index 0 = red, 1 = green, 2 = blue throughout.
  logic          s1_valid_r;
  logic          s1_end_r;
  logic [XW-1:0] s1_x_r;
  logic [YW-1:0] s1_y_r;
  logic [CW-1:0] s1_cost_r [3];

  logic [CW-1:0] best_r    [3];
  logic [XW-1:0] bx_r      [3];
  logic [YW-1:0] by_r      [3];
  logic [HW-1:0] hits_r    [3];

  logic [2:0]    hit_s;
  logic [CW-1:0] best_nx_s [3];
  logic [XW-1:0] bx_nx_s   [3];
  logic [YW-1:0] by_nx_s   [3];
  logic [HW-1:0] hits_nx_s [3];

  logic [2:0]    found_nx_s;
  logic [XW-1:0] out_x_nx_s [3];
  logic [YW-1:0] out_y_nx_s [3];

  logic [XW-1:0] out_x_r   [3];
  logic [YW-1:0] out_y_r   [3];
  logic [2:0]    found_r;
  logic          result_valid_r;
  logic          busy_r;

  state_t        state_r;
  state_t        state_nx_s;
  logic          clr_s;
  logic          acc_s;
  logic          load_s;

  // Input stage: every pixel-side input is registered once before comparing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_end_r   <= 1'b0;
      s1_x_r     <= {XW{1'b0}};
      s1_y_r     <= {YW{1'b0}};
      for (int c = 0; c < 3; c++) begin
        s1_cost_r[c] <= {CW{1'b0}};
      end
    end else begin
      s1_valid_r   <= pixel_valid;
      s1_end_r     <= frame_end;
      s1_x_r       <= pixel_x;
      s1_y_r       <= pixel_y;
      s1_cost_r[0] <= red_cost;
      s1_cost_r[1] <= green_cost;
      s1_cost_r[2] <= blue_cost;
    end
  end

  // Per-colour next accumulator values for the staged pixel. Strict '>' keeps
  // the first pixel in raster order on ties.
  always_comb begin
    hit_s = 3'b000;
    for (int c = 0; c < 3; c++) begin
      hit_s[c] = s1_valid_r && (s1_cost_r[c] >= MIN_COST_C);
      if (hit_s[c] && (s1_cost_r[c] > best_r[c])) begin
        best_nx_s[c] = s1_cost_r[c];
        bx_nx_s[c]   = s1_x_r;
        by_nx_s[c]   = s1_y_r;
      end else begin
        best_nx_s[c] = best_r[c];
        bx_nx_s[c]   = bx_r[c];
        by_nx_s[c]   = by_r[c];
      end
      if (hit_s[c]) begin
        hits_nx_s[c] = sat_inc(hits_r[c]);
      end else begin
        hits_nx_s[c] = hits_r[c];
      end
    end
  end

  // Report values. They are built from the next accumulator values so a
  // pixel staged together with frame_end is part of the reported frame.
  always_comb begin
    found_nx_s = 3'b000;
    for (int c = 0; c < 3; c++) begin
      found_nx_s[c] = (hits_nx_s[c] >= MIN_HITS_C);
      if (found_nx_s[c]) begin
        out_x_nx_s[c] = bx_nx_s[c];
        out_y_nx_s[c] = by_nx_s[c];
      end else begin
`ifdef TRACK_HOLD_EN
        out_x_nx_s[c] = out_x_r[c];
        out_y_nx_s[c] = out_y_r[c];
`else
        out_x_nx_s[c] = {XW{1'b0}};
        out_y_nx_s[c] = {YW{1'b0}};
`endif
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and datapath controls. frame_start always restarts
  // accumulation; a restart wins over a coincident staged frame_end.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    acc_s      = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_nx_s = ST_ACCUM;
          clr_s      = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (frame_start) begin
          state_nx_s = ST_ACCUM;
          clr_s      = 1'b1;
        end else if (s1_end_r) begin
          state_nx_s = ST_REPORT;
          acc_s      = 1'b1;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_ACCUM;
          acc_s      = 1'b1;
        end
      end
      ST_REPORT: begin
        clr_s = 1'b1;
        if (frame_start) begin
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        clr_s      = 1'b1;
      end
    endcase
  end

  // Per-colour accumulators: best cost, its coordinate and hit count.
  always_ff @(posedge clk) begin
    if (reset || clr_s) begin
      for (int c = 0; c < 3; c++) begin
        best_r[c] <= {CW{1'b0}};
        bx_r[c]   <= {XW{1'b0}};
        by_r[c]   <= {YW{1'b0}};
        hits_r[c] <= {HW{1'b0}};
      end
    end else if (acc_s) begin
      for (int c = 0; c < 3; c++) begin
        best_r[c] <= best_nx_s[c];
        bx_r[c]   <= bx_nx_s[c];
        by_r[c]   <= by_nx_s[c];
        hits_r[c] <= hits_nx_s[c];
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        best_r[c] <= best_r[c];
        bx_r[c]   <= bx_r[c];
        by_r[c]   <= by_r[c];
        hits_r[c] <= hits_r[c];
      end
    end
  end

  // Registered outputs: targets change only when a report is loaded, which
  // coincides with entering REPORT so result_valid is high during REPORT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        out_x_r[c] <= {XW{1'b0}};
        out_y_r[c] <= {YW{1'b0}};
      end
      found_r        <= 3'b000;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      if (load_s) begin
        for (int c = 0; c < 3; c++) begin
          out_x_r[c] <= out_x_nx_s[c];
          out_y_r[c] <= out_y_nx_s[c];
        end
        found_r <= found_nx_s;
      end else begin
        found_r <= found_r;
      end
      result_valid_r <= load_s;
      busy_r         <= (state_nx_s != ST_IDLE);
    end
  end

  assign red_x        = out_x_r[0];
  assign red_y        = out_y_r[0];
  assign green_x      = out_x_r[1];
  assign green_y      = out_y_r[1];
  assign blue_x       = out_x_r[2];
  assign blue_y       = out_y_r[2];
  assign red_found    = found_r[0];
  assign green_found  = found_r[1];
  assign blue_found   = found_r[2];
  assign result_valid = result_valid_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_color_peak_tracker.sv
// Directed testbench for color_peak_tracker with an expected-result queue.
module tb_color_peak_tracker;

  logic       clk = 1'b0;
  logic       reset, frame_start, frame_end, pixel_valid;
  logic [9:0] pixel_x, pixel_y;
  logic [8:0] red_cost, green_cost, blue_cost;
  logic [9:0] red_x, red_y, green_x, green_y, blue_x, blue_y;
  logic       red_found, green_found, blue_found, result_valid, busy;

  always #5 clk = ~clk;

  color_peak_tracker dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .red_cost(red_cost), .green_cost(green_cost), .blue_cost(blue_cost),
    .red_x(red_x), .red_y(red_y), .green_x(green_x), .green_y(green_y),
    .blue_x(blue_x), .blue_y(blue_y), .red_found(red_found),
    .green_found(green_found), .blue_found(blue_found),
    .result_valid(result_valid), .busy(busy)
  );

  typedef struct {
    logic       f [3];
    logic [9:0] x [3];
    logic [9:0] y [3];
  } exp_t;

  exp_t       sb_q [$];
  logic [9:0] prev_x [3];
  logic [9:0] prev_y [3];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [9:0] pick(input logic f, input logic [9:0] nv, input logic [9:0] pv);
`ifdef TRACK_HOLD_EN
    return f ? nv : pv;
`else
    return f ? nv : 10'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected report for the frame being closed; coords only matter when found.
  task automatic push_exp(input logic rf, input logic [9:0] rx, input logic [9:0] ry,
                          input logic gf, input logic [9:0] gx, input logic [9:0] gy,
                          input logic bf, input logic [9:0] bx, input logic [9:0] by);
    exp_t e;
    e.f[0] = rf; e.x[0] = pick(rf, rx, prev_x[0]); e.y[0] = pick(rf, ry, prev_y[0]);
    e.f[1] = gf; e.x[1] = pick(gf, gx, prev_x[1]); e.y[1] = pick(gf, gy, prev_y[1]);
    e.f[2] = bf; e.x[2] = pick(bf, bx, prev_x[2]); e.y[2] = pick(bf, by, prev_y[2]);
    for (int c = 0; c < 3; c++) begin
      prev_x[c] = e.x[c];
      prev_y[c] = e.y[c];
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic fs, input logic fe, input logic v,
                       input logic [9:0] x, input logic [9:0] y,
                       input logic [8:0] r, input logic [8:0] g, input logic [8:0] b);
    frame_start = fs; frame_end = fe; pixel_valid = v;
    pixel_x = x; pixel_y = y; red_cost = r; green_cost = g; blue_cost = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
  endtask

  task automatic clear_inputs();
    frame_start = 1'b0; frame_end = 1'b0; pixel_valid = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; red_cost = 9'd0; green_cost = 9'd0; blue_cost = 9'd0;
  endtask

  // Called right after the frame_end cycle; waits (bounded) for the report.
  task automatic wait_report(input string tag);
    int   n;
    logic seen;
    exp_t e;
    logic [9:0] ox [3];
    logic [9:0] oy [3];
    logic       of [3];
    clear_inputs();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (result_valid) seen = 1'b1;
    end
    chk({tag, "_rv_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(n), 32'd1);
      ox[0] = red_x;   oy[0] = red_y;   of[0] = red_found;
      ox[1] = green_x; oy[1] = green_y; of[1] = green_found;
      ox[2] = blue_x;  oy[2] = blue_y;  of[2] = blue_found;
      if (sb_q.size() == 0) begin
        chk({tag, "_unexpected_report"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("%s_c%0d_found", tag, c), 32'(of[c]), 32'(e.f[c]));
          chk($sformatf("%s_c%0d_x", tag, c), 32'(ox[c]), 32'(e.x[c]));
          chk($sformatf("%s_c%0d_y", tag, c), 32'(oy[c]), 32'(e.y[c]));
        end
      end
      @(negedge clk);
      chk({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic expect_no_report(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    chk({tag, "_no_rv"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      prev_x[c] = 10'd0;
      prev_y[c] = 10'd0;
    end
    clear_inputs();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_red_x", 32'(red_x), 32'd0);
    chk("rst_blue_y", 32'(blue_y), 32'd0);
    chk("rst_found", 32'({red_found, green_found, blue_found}), 32'd0);

    // T1: five red hits at (10..14,2)
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 10'(10 + i), 10'd2, 9'd6, 9'd0, 9'd0);
    push_exp(1'b1, 10'd10, 10'd2, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    wait_report("t1");

    // T2: red 5,9,9,7 -> first of the tied 9s wins
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd1, 10'd0, 9'd5, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd2, 10'd0, 9'd9, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd3, 10'd0, 9'd9, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd4, 10'd0, 9'd7, 9'd0, 9'd0);
    push_exp(1'b1, 10'd2, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    wait_report("t2");

    // T3a: green found at (20,7); red not found this frame
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 10'(20 + i), 10'd7, 9'd0, 9'd10, 9'd0);
    push_exp(1'b0, 10'd0, 10'd0, 1'b1, 10'd20, 10'd7, 1'b0, 10'd0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    wait_report("t3a");

    // T3b: only two green hits -> green not found
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd3, 10'd3, 9'd0, 9'd8, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd4, 10'd3, 9'd0, 9'd8, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd5, 10'd3, 9'd0, 9'd3, 9'd0);
    push_exp(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    wait_report("t3b");

    // T4: restart mid-frame discards the red 12 peak
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd50, 10'd40, 9'd12, 9'd0, 9'd0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 10'd5, 10'd5, 9'd7, 9'd0, 9'd0);
    push_exp(1'b1, 10'd5, 10'd5, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    wait_report("t4");

    // T5: peak pixel coincident with frame_end
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 9'd0, 9'd0, 9'd5);
    drive(1'b0, 1'b0, 1'b1, 10'd1, 10'd0, 9'd0, 9'd0, 9'd5);
    push_exp(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 10'd639, 10'd479);
    drive(1'b0, 1'b1, 1'b1, 10'd639, 10'd479, 9'd0, 9'd0, 9'd15);
    wait_report("t5");
    idle(3);
    chk("t5_hold_x", 32'(blue_x), 32'd639);
    chk("t5_hold_found", 32'(blue_found), 32'd1);

    // T6: reset mid-frame, then frame_end -> no report, outputs cleared
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 10'(30 + i), 10'd9, 9'd20, 9'd0, 9'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      prev_x[c] = 10'd0;
      prev_y[c] = 10'd0;
    end
    drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 9'd0, 9'd0, 9'd0);
    clear_inputs();
    expect_no_report("t6", 6);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_blue_x", 32'(blue_x), 32'd0);
    chk("t6_found", 32'({red_found, green_found, blue_found}), 32'd0);

    // frame_end with a pixel while IDLE is ignored
    drive(1'b0, 1'b1, 1'b1, 10'd7, 10'd7, 9'd30, 9'd30, 9'd30);
    clear_inputs();
    expect_no_report("idle_fe", 5);
    chk("idle_red_x", 32'(red_x), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
